// File: rtl/mem_cycle_seq.sv
// Memory-cycle sequencer: expands a one-cycle access request into a fixed
// four-T-state external bus cycle and drives the data-latch controls.
module mem_cycle_seq #(
  parameter int AW = 16,
  parameter int DW = 8
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          req,
  input  logic          we,
  input  logic [AW-1:0] addr_in,
  input  logic [DW-1:0] wdata_in,
  input  logic          hold,
  input  logic [DW-1:0] dl_in,
  output logic [AW-1:0] A,
  output logic          nRD,
  output logic          nWR,
  output logic          DL_Control1,
  output logic          DL_Control2,
  output logic [DW-1:0] Res,
  output logic [DW-1:0] rdata,
  output logic          busy,
  output logic          done
);

  typedef enum logic [4:0] {
    S_IDLE = 5'b00001,
    S_T1   = 5'b00010,
    S_T2   = 5'b00100,
    S_T3   = 5'b01000,
    S_T4   = 5'b10000
  } state_e;

  typedef struct packed {
    logic nrd;
    logic nwr;
    logic dlc1;
    logic dlc2;
    logic busy;
    logic done;
  } ctl_t;

  localparam ctl_t CTL_IDLE = '{nrd: 1'b1, nwr: 1'b1, dlc1: 1'b1, dlc2: 1'b0,
                                busy: 1'b0, done: 1'b0};

  state_e          state_q, state_d;
  logic            we_q, we_d;
  logic            start;
  ctl_t            ctl_q;
  logic [AW-1:0]   addr_q;
  logic [DW-1:0]   res_q;
  logic [DW-1:0]   rdata_q;

  // Bus strobes and latch controls for a given T-state and direction.
  function automatic ctl_t decode(state_e s, logic w);
    ctl_t c;
    c = CTL_IDLE;
    case (s)
      S_T1: begin
        c.busy = 1'b1;
        c.dlc1 = 1'b1;
        c.nrd  = w;
        c.dlc2 = w;
      end
      S_T2, S_T3: begin
        c.busy = 1'b1;
        c.dlc1 = 1'b0;
        c.nrd  = w;
        c.nwr  = !w;
        c.dlc2 = w;
      end
      S_T4: begin
        c.busy = 1'b1;
        c.done = 1'b1;
        c.dlc1 = w;
      end
      default: c = CTL_IDLE;
    endcase
    return c;
  endfunction

  // NOTE: every variable assigned in this block gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    start   = 1'b0;
    state_d = state_q;
    we_d    = we_q;
    case (state_q)
      S_IDLE: begin
        start   = req && !hold;
        state_d = start ? S_T1 : S_IDLE;
      end
      S_T1: state_d = S_T2;
      S_T2: state_d = S_T3;
      S_T3: state_d = S_T4;
      S_T4: begin
        start   = req && !hold;
        state_d = start ? S_T1 : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (start) we_d = we;
  end

  // NOTE: outputs are flopped from the next-state decode, so each strobe is a
  // register output aligned with its T-state; nonblocking assignments keep all
  // flops updating together on the edge.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= S_IDLE;
      we_q    <= 1'b0;
      ctl_q   <= CTL_IDLE;
      addr_q  <= '0;
      res_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      ctl_q   <= decode(state_d, we_d);
      if (start) begin
        addr_q <= addr_in;
        res_q  <= wdata_in;
      end
      // The read byte is on DL during T3; keep it for the T4 done pulse.
      if (state_q == S_T3 && !we_q) rdata_q <= dl_in;
    end
  end

  assign A           = addr_q;
  assign Res         = res_q;
  assign rdata       = rdata_q;
  assign nRD         = ctl_q.nrd;
  assign nWR         = ctl_q.nwr;
  assign DL_Control1 = ctl_q.dlc1;
  assign DL_Control2 = ctl_q.dlc2;
  assign busy        = ctl_q.busy;
  assign done        = ctl_q.done;

endmodule

// File: doc/mem_cycle_seq.md
Name: mem_cycle_seq

Overview:
- Memory-cycle sequencer sitting directly upstream of the external data latch.
- Turns a single-cycle access request from the decoder into a 4-T-state bus cycle.
- Drives address pins, nRD/nWR strobes, latch controls DL_Control1 (1 = bus disable) and DL_Control2 (ALU result -> DL), plus the write byte on Res.
- Captures the read byte from the internal DL bus and returns it with a done pulse.

Parameters:
AW, 16, address width
DW, 8, data width (DataBus/DL/Res width)

Ports:
CLK  in  1  system clock; all state changes on rising edge
RESET  in  1  synchronous, active-high reset
req  in  1  access request, sampled in IDLE or T4
we  in  1  1 = write, 0 = read; sampled with req
addr_in  in  AW  access address; sampled with req
wdata_in  in  DW  write byte (ALU result); sampled with req
hold  in  1  bus hold (DMA/halt); blocks start of a new cycle
dl_in  in  DW  internal DL bus value from data latch
A  out  AW  external address pins
nRD  out  1  read strobe, active low
nWR  out  1  write strobe, active low
DL_Control1  out  1  data latch bus disable (1 = disabled)
DL_Control2  out  1  Res -> DL enable
Res  out  DW  registered write byte to data latch
rdata  out  DW  captured read byte
busy  out  1  cycle in progress (T1..T4)
done  out  1  one-cycle pulse in T4

Behaviour:
- State register: one-hot IDLE, T1, T2, T3, T4.
- All strobe and control outputs decode from state plus the latched we bit. The decode must be glitch-free; combinational paths from inputs to outputs are forbidden.
- Reset (synchronous, overrides everything, including mid-cycle):
  - state = IDLE, A = 0, Res = 0, rdata = 0, we_q = 0.
  - Outputs: nRD = 1, nWR = 1, DL_Control1 = 1, DL_Control2 = 0, busy = 0, done = 0.
  - An aborted cycle is not retried and produces no done.
- Start condition: (state == IDLE or T4) and req and !hold and !RESET.
  - Next state is T1.
  - A <= addr_in, Res <= wdata_in, we_q <= we.
  - Otherwise IDLE holds, and T4 returns to IDLE.
- Fixed progression: T1 -> T2 -> T3 -> T4. No wait states.
- hold is ignored once a cycle has begun.
- Per-state outputs, read (we_q = 0):
  - T1: nRD = 0, DL_Control1 = 1.
  - T2, T3: nRD = 0, DL_Control1 = 0.
  - T4: nRD = 1, DL_Control1 = 0, done = 1.
  - nWR = 1 and DL_Control2 = 0 throughout.
- Per-state outputs, write (we_q = 1):
  - T1: DL_Control2 = 1, DL_Control1 = 1, nWR = 1.
  - T2, T3: DL_Control2 = 1, DL_Control1 = 0, nWR = 0.
  - T4: nWR = 1, DL_Control1 = 1, DL_Control2 = 0, done = 1.
  - nRD = 1 throughout.
- busy = 1 in T1..T4, 0 in IDLE.
- IDLE outputs equal the reset output values, except A and Res, which hold their last values.
- Read capture: rdata <= dl_in on the T3 -> T4 edge, so rdata is valid during the T4 done pulse. rdata holds until the next read capture. Writes never modify rdata.
- Latency: req seen in IDLE gives done 4 cycles later (T4). Back-to-back requests give one access every 4 cycles with no IDLE gap.
- Simultaneous req and hold: hold wins and no cycle starts. req is level-sampled; the requester keeps it asserted until it sees busy.
- Address wrap: A is a plain register; 0xFFFF -> 0x0000 has no special case.
- Input changes while busy: addr_in and wdata_in changes after start do not affect A or Res until the next start.

Test Plan:
- Read: req = 1, we = 0, addr_in = 0xC123, dl_in = 0x5A from T2 -> nRD low T1..T3, DL_Control1 = 1, 0, 0, 0 over T1..T4, A = 0xC123, done in T4 with rdata = 0x5A, then IDLE with nRD = 1.
- Write: req = 1, we = 1, addr_in = 0xFF80, wdata_in = 0x3C -> Res = 0x3C from T1, DL_Control2 high T1..T3, nWR low exactly T2..T3, nRD stays 1, done in T4, rdata unchanged.
- Back-to-back: read 0x0100 then write 0x0101, req held -> second T1 immediately follows first T4, done pulses 4 cycles apart, A = 0x0100 then 0x0101.
- Hold: hold = 1 with req = 1 for 5 cycles -> stays IDLE, busy = 0. hold deasserts -> T1 next cycle. hold asserted at T2 -> cycle completes normally.
- Reset mid-cycle: RESET at T2 of a write -> next edge shows IDLE, nWR = 1, DL_Control2 = 0, DL_Control1 = 1, A = 0, no done, and no spurious cycle after reset releases with req = 0.
- Stable inputs: change addr_in to 0xFFFF during T2 -> A keeps the latched value through T4, and the next cycle uses 0xFFFF.
